// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, fetch FSM state encoding and instruction field helpers
package cpu_pkg;
    localparam int INSTR_W      = 8;
    localparam int OPCODE_MSB   = 7;
    localparam int OPCODE_LSB   = 4;
    localparam int OPERAND_MSB  = 3;
    localparam int OPERAND_LSB  = 0;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_RESET_PC = 0;

    typedef logic [1:0] fetch_state_t;
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] i);
        return i[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [OPERAND_MSB-OPERAND_LSB:0] operand_of(input logic [INSTR_W-1:0] i);
        return i[OPERAND_MSB:OPERAND_LSB];
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, instr} pairs with flush; head is read combinationally
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    output logic [CW-1:0]      count,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);
    logic [ADDR_W+INSTR_W-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign {head_pc, head_instr} = mem[rd_ptr];

    // pointer and occupancy update; flush empties the queue regardless of push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage write; entries need no reset since the head is only consumed while count != 0
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= {push_pc, push_instr};
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, 1-cycle ROM read and instruction queue feeding decode.
// Define FETCH_STATS_EN to add bubble_cnt (saturating count of ready && !valid cycles).
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W                = DEF_ADDR_W,
    parameter int DEPTH                 = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               valid,
    input  logic               ready,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]        bubble_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t state;
    logic [ADDR_W-1:0] fetch_pc, resp_pc, head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic inflight;
    logic [CW-1:0] count;

    assign valid     = count != '0;
    assign instr     = valid ? head_instr : '0;
    assign pc_out    = valid ? head_pc : '0;
    assign imem_en   = state == S_RUN && count + CW'(inflight) < CW'(DEPTH);
    assign imem_addr = fetch_pc;

    // FSM and PC sequencing; redirect overrides issue and kills the outstanding read
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect) begin
            state    <= S_REDIR;
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            state    <= S_RUN;
            inflight <= imem_en;
            if (imem_en) begin
                fetch_pc <= fetch_pc + 1'b1;
                resp_pc  <= fetch_pc;
            end
        end
    end

    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (inflight),
        .push_pc   (resp_pc),
        .push_instr(imem_data),
        .pop       (valid && ready),
        .count     (count),
        .head_pc   (head_pc),
        .head_instr(head_instr)
    );

`ifdef FETCH_STATS_EN
    // decode-starvation counter, saturating; survives redirects
    always_ff @(posedge clk)
        if (rst) bubble_cnt <= '0;
        else if (ready && !valid && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 1'b1;
`endif
endmodule
